// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED driver.
package led_pkg;

  // Per-channel operating mode; encodings match the cfg_mode port values.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  // Minimum-1 width helper for counters and selects.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Blink time-base prescaler: counts 0..TICK_DIV-1 and flags the last count.
module led_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;

  // Next count with wrap at TICK_DIV-1.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Count register plus a registered tick that is high while the count sits at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED driver: OFF / ON / BLINK / PWM per channel, registered pins.
module led_ctrl
  import led_pkg::*;
#(
  parameter int unsigned LED_NUM    = 3,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned ARG_W      = 4,
  parameter int unsigned SEL_W      = clog2_min1(LED_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [1:0]         cfg_mode,
  input  logic [ARG_W-1:0]   cfg_arg,
  output logic [LED_NUM-1:0] led,
  output logic               tick
);

  logic [ARG_W-1:0]   pwm_cnt_q;
  logic [LED_NUM-1:0] lit;

  led_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Free-running PWM reference shared by all channels; unaffected by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
    // Select value addressing this channel; values >= LED_NUM never match any channel.
    localparam logic [SEL_W-1:0] CH_SEL = SEL_W'(i);

    mode_e            mode_q, mode_d;
    logic [ARG_W-1:0] arg_q, arg_d;
    logic [ARG_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             wr_hit;
    logic             lit_ch;

    assign wr_hit = cfg_we && (cfg_sel == CH_SEL);

    // Next channel state: clr beats a write, a write beats a blink tick.
    always_comb begin
      mode_d  = mode_q;
      arg_d   = arg_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (clr) begin
        mode_d  = MODE_OFF;
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (wr_hit) begin
        mode_d  = mode_e'(cfg_mode);
        arg_d   = cfg_arg;
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if ((mode_q == MODE_BLINK) && tick) begin
        if (cnt_q == arg_q) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q  <= MODE_OFF;
        arg_q   <= '0;
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        arg_q   <= arg_d;
        cnt_q   <= cnt_d;
        phase_q <= phase_d;
      end
    end

    // Lit term decoded from the registered mode and state.
    always_comb begin
      lit_ch = 1'b0;
      case (mode_q)
        MODE_OFF:   lit_ch = 1'b0;
        MODE_ON:    lit_ch = 1'b1;
        MODE_BLINK: lit_ch = phase_q;
        MODE_PWM:   lit_ch = (pwm_cnt_q < arg_q);
        default:    lit_ch = 1'b0;
      endcase
    end

    assign lit[i] = lit_ch;
  end

  // Registered pin drive with polarity applied; reset leaves every LED dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= {LED_NUM{ACTIVE_LOW}};
    end else begin
      led <= lit ^ {LED_NUM{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: vector table, hand sequences, random traffic vs model.
module tb_led_ctrl;

  localparam int LN = 3;
  localparam int TD = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_sel = '0;
  logic [1:0]    cfg_mode = '0;
  logic [AW-1:0] cfg_arg = '0;
  logic [LN-1:0] led;
  logic          tick;

  int n_tests = 0;
  int n_fail  = 0;

  led_ctrl #(
    .LED_NUM   (LN),
    .ACTIVE_LOW(1'b1),
    .TICK_DIV  (TD),
    .ARG_W     (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_mode(cfg_mode),
    .cfg_arg (cfg_arg),
    .led     (led),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // n: edges since reset release. Prescaler count before edge n+1 is n%TD,
  // PWM count is n%16. Blink phase follows from ticks elapsed since the last write.
  int          n = 0;
  int          mmode[LN];
  int          marg[LN];
  int          mtk[LN];
  logic [LN-1:0] exp_led = '1;
  logic [LN-1:0] mlit;
  bit          tk_now;

  function automatic bit model_lit(int c, int nn);
    case (mmode[c])
      1:       return 1'b1;
      2:       return ((mtk[c] / (marg[c] + 1)) % 2) == 0;
      3:       return (nn % 16) < marg[c];
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    for (int c = 0; c < LN; c++) begin
      mmode[c] = 0; marg[c] = 0; mtk[c] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      exp_led = '1;
      for (int c = 0; c < LN; c++) begin
        mmode[c] = 0; marg[c] = 0; mtk[c] = 0;
      end
    end else begin
      tk_now = (n % TD) == TD - 1;
      for (int c = 0; c < LN; c++) mlit[c] = model_lit(c, n);
      exp_led = ~mlit;
      if (clr) begin
        for (int c = 0; c < LN; c++) begin
          mmode[c] = 0; mtk[c] = 0;
        end
      end else begin
        for (int c = 0; c < LN; c++)
          if (mmode[c] == 2 && tk_now) mtk[c]++;
        if (cfg_we && int'(cfg_sel) < LN) begin
          mmode[cfg_sel] = int'(cfg_mode);
          marg[cfg_sel]  = int'(cfg_arg);
          mtk[cfg_sel]   = 0;
        end
      end
      n++;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit auto_chk = 1'b0;

  // Advance to the next falling edge and compare against the model.
  task automatic step();
    @(negedge clk);
    if (rst_n && auto_chk) begin
      check("led_model", int'(led), int'(exp_led));
      check("tick_model", int'(tick), int'((n % TD) == TD - 1));
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(); clr = 1'b0; step();
  endtask

  task automatic write_ch(input logic [1:0] sel, input logic [1:0] mode, input logic [AW-1:0] arg);
    cfg_we = 1'b1; cfg_sel = sel; cfg_mode = mode; cfg_arg = arg;
    step();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    string         name;
    bit            we;
    bit            clr;
    logic [1:0]    sel;
    logic [1:0]    mode;
    logic [AW-1:0] arg;
    logic [LN-1:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int prev, last, toggles, cnt;

    vt[0] = '{"on_ch1",      1, 0, 2'd1, 2'd1, 4'd0, 3'b101};
    vt[1] = '{"off_ch1",     1, 0, 2'd1, 2'd0, 4'd0, 3'b111};
    vt[2] = '{"on_ch0",      1, 0, 2'd0, 2'd1, 4'd0, 3'b110};
    vt[3] = '{"on_ch2",      1, 0, 2'd2, 2'd1, 4'd0, 3'b010};
    vt[4] = '{"sel_oob",     1, 0, 2'd3, 2'd1, 4'd0, 3'b010};
    vt[5] = '{"clr_wins",    1, 1, 2'd1, 2'd1, 4'd0, 3'b111};
    vt[6] = '{"pwm_arg0",    1, 0, 2'd2, 2'd3, 4'd0, 3'b111};
    vt[7] = '{"on_ch1_b",    1, 0, 2'd1, 2'd1, 4'd0, 3'b101};
    vt[8] = '{"blink_start", 1, 0, 2'd0, 2'd2, 4'd5, 3'b100};
    vt[9] = '{"clr_only",    0, 1, 2'd0, 2'd0, 4'd0, 3'b111};

    // Reset state and prescaler cadence.
    repeat (3) @(negedge clk);
    check("reset_led", int'(led), 7);
    check("reset_tick", int'(tick), 0);
    rst_n = 1'b1;
    auto_chk = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("tick_cadence", int'(tick), int'((i % 4) == 3));
      check("idle_led", int'(led), 7);
    end

    // Vector table.
    for (int v = 0; v < 10; v++) begin
      cfg_we = vt[v].we; clr = vt[v].clr;
      cfg_sel = vt[v].sel; cfg_mode = vt[v].mode; cfg_arg = vt[v].arg;
      step();
      cfg_we = 1'b0; clr = 1'b0;
      step();
      check(vt[v].name, int'(led), int'(vt[v].exp));
    end

    // Blink arg=1: lit right after the write, then toggles every 8 cycles.
    write_ch(2'd0, 2'd2, 4'd1);
    step();
    check("blink_first", int'(led[0]), 0);
    prev = int'(led[0]); last = -1; toggles = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (int'(led[0]) != prev) begin
        if (last >= 0) check("blink_period", i - last, 8);
        last = i; prev = int'(led[0]); toggles++;
      end
    end
    check("blink_toggles", int'(toggles >= 5), 1);
    pulse_clr();
    check("clr_blink", int'(led), 7);

    // PWM duty 4/16, then arg=0 stays dark.
    write_ch(2'd2, 2'd3, 4'd4);
    step();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (led[2] == 1'b0) cnt++;
    end
    check("pwm_duty4", cnt, 8);
    write_ch(2'd2, 2'd3, 4'd0);
    step();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (led[2] == 1'b0) cnt++;
    end
    check("pwm_duty0", cnt, 0);

    // Full-scale PWM.
    write_ch(2'd1, 2'd3, 4'd15);
    step();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (led[1] == 1'b0) cnt++;
    end
    check("pwm_duty15", cnt, 30);
    pulse_clr();

    // Asynchronous reset mid-blink, then prescaler restart.
    write_ch(2'd0, 2'd2, 4'd0);
    repeat (5) step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(led), 7);
    check("async_rst_tick", int'(tick), 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("post_rst_tick", int'(tick), int'((i % 4) == 3));
    end

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      cfg_we   = ($urandom % 3) == 0;
      cfg_sel  = 2'($urandom_range(0, 3));
      cfg_mode = 2'($urandom % 4);
      cfg_arg  = (($urandom % 2) == 0) ? AW'($urandom_range(0, 2)) : AW'($urandom % 16);
      clr      = ($urandom % 40) == 0;
      step();
    end
    cfg_we = 1'b0; clr = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
